// File: rtl/snd_dma_pkg.sv
// ============================================================================
// Module      : snd_dma_pkg
// Description : Shared types for the sound-sample DMA read controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snd_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETADDR = 2'd1,
    S_READ    = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_PLAY  = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_t;

  // Loop count value that means "repeat forever".
  localparam logic [7:0] c_loop_inf = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/snd_burst_calc.sv
// ============================================================================
// Module      : snd_burst_calc
// Description : Combinational burst sizing: ARLEN and byte increment from the
//               remaining beat count, clipped to MAX_BEATS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snd_burst_calc #(
  parameter int ADDR_W     = 32,
  parameter int SIZE_W     = 29,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic [SIZE_W-1:0] i_rem,
  output logic [7:0]        o_arlen,
  output logic [ADDR_W-1:0] o_incr
);

  localparam int c_beat_shift = $clog2(BEAT_BYTES);

  logic [SIZE_W-1:0] w_beats;

  always_comb begin
    w_beats = (i_rem > SIZE_W'(MAX_BEATS)) ? SIZE_W'(MAX_BEATS) : i_rem;
    // A zero count never reaches the bus; keep ARLEN at 0 rather than wrap.
    o_arlen = (w_beats == '0) ? 8'd0 : 8'(w_beats - SIZE_W'(1));
    o_incr  = ADDR_W'(w_beats) << c_beat_shift;
  end

endmodule

`default_nettype wire

// File: rtl/snd_dmactrl.sv
// ============================================================================
// Module      : snd_dmactrl
// Description : AXI4 read-address/handshake controller streaming a DRAM sound
//               region into the sample FIFO with play/pause/stop/loop.
//               Optional macro SND_LOOPCNT_EN adds the LOOPCNT pass counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snd_dmactrl
  import snd_dma_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                SIZE_W     = 29,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h2000_0000,
  parameter int                BEAT_BYTES = 8,
  parameter int                MAX_BEATS  = 16
) (
  input  logic              ACLK,
  input  logic              ARST,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic              RLAST,
  output logic              RREADY,
  input  logic [SIZE_W-1:0] SNDADDR,
  input  logic [SIZE_W-1:0] DATASIZE,
  input  logic [1:0]        COMMAND,
  input  logic              LOOP,
  input  logic              BUF_WREADY,
`ifdef SND_LOOPCNT_EN
  input  logic [7:0]        LOOPCNT,
`endif
  output logic              BUSY,
  output logic              DONE
);

  localparam int c_beat_shift = $clog2(BEAT_BYTES);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [SIZE_W-1:0]   r_rem;
  logic [7:0]          r_arlen;
  logic [ADDR_W-1:0]   r_incr;
  logic                r_arvalid;
  logic                r_done;
  logic                r_stop_lat;
`ifdef SND_LOOPCNT_EN
  logic [7:0]          r_loopcnt;
`endif

  logic [SIZE_W:0]     w_tb_sum;
  logic [SIZE_W-1:0]   w_tb;
  logic [ADDR_W-1:0]   w_region;
  logic [SIZE_W-1:0]   w_rem_after;
  logic [SIZE_W-1:0]   w_calc_rem;
  logic [7:0]          w_calc_arlen;
  logic [ADDR_W-1:0]   w_calc_incr;
  logic                w_stop;
  logic                w_pause;
  logic                w_play;
  logic                w_last;
  logic                w_restart;

  assign w_stop  = (COMMAND == CMD_STOP);
  assign w_pause = (COMMAND == CMD_PAUSE);
  assign w_play  = (COMMAND == CMD_PLAY);
  assign w_last  = RVALID && RLAST;

  assign w_tb_sum = {1'b0, DATASIZE} + (SIZE_W + 1)'(BEAT_BYTES - 1);
  assign w_tb     = SIZE_W'(w_tb_sum >> c_beat_shift);
  assign w_region = BASE_ADDR + ADDR_W'(SNDADDR);

`ifdef SND_LOOPCNT_EN
  assign w_restart = LOOP && (w_tb != '0) && (r_loopcnt != 8'd0);
`else
  assign w_restart = LOOP && (w_tb != '0);
`endif

  // Size the next burst from the count REM is about to hold.
  always_comb begin
    w_rem_after = r_rem - SIZE_W'(r_arlen) - SIZE_W'(1);
    w_calc_rem  = w_tb;
    if ((r_state == S_READ) && (w_rem_after != '0))
      w_calc_rem = w_rem_after;
  end

  snd_burst_calc #(
    .ADDR_W     (ADDR_W),
    .SIZE_W     (SIZE_W),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BEATS  (MAX_BEATS)
  ) u_burst_calc (
    .i_rem   (w_calc_rem),
    .o_arlen (w_calc_arlen),
    .o_incr  (w_calc_incr)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_arlen    <= 8'd0;
      r_incr     <= '0;
      r_arvalid  <= 1'b0;
      r_done     <= 1'b0;
      r_stop_lat <= 1'b0;
`ifdef SND_LOOPCNT_EN
      r_loopcnt  <= 8'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_play && (DATASIZE != '0)) begin
            r_state    <= S_SETADDR;
            r_arvalid  <= 1'b1;
            r_ptr      <= w_region;
            r_rem      <= w_tb;
            r_arlen    <= w_calc_arlen;
            r_incr     <= w_calc_incr;
            r_stop_lat <= 1'b0;
`ifdef SND_LOOPCNT_EN
            r_loopcnt  <= LOOPCNT;
`endif
          end
        end
        S_SETADDR: begin
          // An accepted address must be drained even if stop arrives with it.
          if (ARREADY) begin
            r_state    <= S_READ;
            r_arvalid  <= 1'b0;
            r_stop_lat <= w_stop;
          end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        S_READ: begin
          if (w_stop)
            r_stop_lat <= 1'b1;
          if (w_last) begin
            r_ptr <= r_ptr + r_incr;
            r_rem <= w_rem_after;
            if (r_stop_lat || w_stop || ((w_rem_after == '0) && !w_restart)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              if (w_rem_after == '0) begin
                r_ptr <= w_region;
                r_rem <= w_tb;
`ifdef SND_LOOPCNT_EN
                if (r_loopcnt != c_loop_inf)
                  r_loopcnt <= r_loopcnt - 8'd1;
`endif
              end
              r_arlen <= w_calc_arlen;
              r_incr  <= w_calc_incr;
              if (w_pause || !BUF_WREADY) begin
                r_state <= S_WAIT;
              end else begin
                r_state   <= S_SETADDR;
                r_arvalid <= 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (!w_pause && BUF_WREADY) begin
            r_state   <= S_SETADDR;
            r_arvalid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ARADDR  = (r_state == S_IDLE) ? w_region : r_ptr;
  assign ARLEN   = r_arlen;
  assign ARVALID = r_arvalid;
  assign RREADY  = (r_state == S_READ) && RVALID;
  assign BUSY    = (r_state != S_IDLE);
  assign DONE    = r_done;

endmodule

`default_nettype wire
